// File: rtl/trade_pkg.sv
// Shared types and widths for the trading controller: FSM states, request kinds, datapath widths.
package trade_pkg;

  localparam int PRICE_W = 8;
  localparam int CASH_W  = 16;
  localparam int POS_W   = 8;

  typedef enum logic [1:0] {IDLE, CHECK, HOLDOFF} state_t;

  typedef enum logic [1:0] {REQ_NONE, REQ_BUY, REQ_SELL, REQ_BOTH} req_t;

endpackage

// File: rtl/key_edge_sync.sv
// Brings an active-low pushbutton into the clk domain and flags its falling edge as a one-cycle press.
module key_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic meta, sync, sync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= key;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign press = sync_d & ~sync;

endmodule

// File: rtl/trade_controller.sv
// Snapshots generator prices on a periodic tick and arbitrates user BUY/SELL presses against cash/position.
module trade_controller
  import trade_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int INIT_CASH   = 1000,
  parameter int MAX_POS     = 15,
  parameter int HOLDOFF_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRICE_W-1:0] buy_price,
  input  logic [PRICE_W-1:0] sell_price,
  input  logic               key_buy,
  input  logic               key_sell,
  output logic [PRICE_W-1:0] bid_q,
  output logic [PRICE_W-1:0] ask_q,
  output logic               snap_valid,
  output logic [CASH_W-1:0]  cash,
  output logic [POS_W-1:0]   position,
  output logic               trade_ok,
  output logic               trade_rej,
  output logic               busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYC - 1);

  function automatic logic [CASH_W-1:0] sat_add(input logic [CASH_W-1:0] a,
                                                input logic [PRICE_W-1:0] b);
    logic [CASH_W:0] s;
    s = {1'b0, a} + {{(CASH_W + 1 - PRICE_W){1'b0}}, b};
    return s[CASH_W] ? {CASH_W{1'b1}} : s[CASH_W-1:0];
  endfunction

  logic          press_buy, press_sell;
  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic          eval_p0, buy_ok, sell_ok, accept, reject;
  logic [CASH_W-1:0] ask_ext;

  key_edge_sync u_key_buy (
    .clk   (clk),
    .reset (reset),
    .key   (key_buy),
    .press (press_buy)
  );

  key_edge_sync u_key_sell (
    .clk   (clk),
    .reset (reset),
    .key   (key_sell),
    .press (press_sell)
  );

  // price snapshot tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt   <= '0;
      bid_q      <= '0;
      ask_q      <= '0;
      snap_valid <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt   <= '0;
      bid_q      <= buy_price;
      ask_q      <= sell_price;
      snap_valid <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // FSM state, latched request and holdoff counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= REQ_NONE;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      hold_cnt <= (state_q == HOLDOFF) ? hold_cnt + HW'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    eval_p0 = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_buy || press_sell) begin
          if (press_buy && press_sell) req_d = REQ_BOTH;
          else if (press_buy)          req_d = REQ_BUY;
          else                         req_d = REQ_SELL;
          state_d = CHECK;
        end
      end
      CHECK: begin
        eval_p0 = 1'b1;
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_cnt == HOLD_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // decision uses the snapshot registers as they stand during CHECK
  assign ask_ext = {{(CASH_W - PRICE_W){1'b0}}, ask_q};
  assign buy_ok  = snap_valid && (cash >= ask_ext) && (position < POS_W'(MAX_POS));
  assign sell_ok = snap_valid && (position != '0);
  assign accept  = eval_p0 && (((req_q == REQ_BUY) && buy_ok) || ((req_q == REQ_SELL) && sell_ok));
  assign reject  = eval_p0 && !accept;

  // committed result: status pulse and account update land on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cash      <= CASH_W'(INIT_CASH);
      position  <= '0;
      trade_ok  <= 1'b0;
      trade_rej <= 1'b0;
    end else begin
      trade_ok  <= accept;
      trade_rej <= reject;
      if (accept && (req_q == REQ_BUY)) begin
        cash     <= cash - ask_ext;
        position <= position + POS_W'(1);
      end else if (accept) begin
        cash     <= sat_add(cash, bid_q);
        position <= position - POS_W'(1);
      end
    end
  end

endmodule

// File: doc/trade_controller.md
Name: trade_controller

Overview:
Sequences the order generator's price stream into a playable market.
- Periodically snapshots the generator's bid/ask into stable registers for display and trading.
- Accepts user BUY/SELL key presses and arbitrates each press against the current snapshot.
- Maintains cash and position registers, and pulses accept/reject status.
- Sits between order_generator and the display/LED logic in the top level.

Parameters:
TICK_DIV, 50000000, clk cycles between price snapshots (1 s at 50 MHz); must be >= 2
INIT_CASH, 1000, cash value loaded on reset (16-bit)
MAX_POS, 15, maximum units held (8-bit)
HOLDOFF_CYC, 1000, cycles after each decision during which key presses are ignored; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
buy_price  input  8  generator bid (user sells at this price)
sell_price  input  8  generator ask (user buys at this price)
key_buy  input  1  raw pushbutton, active-low, asynchronous to clk
key_sell  input  1  raw pushbutton, active-low, asynchronous to clk
bid_q  output  8  snapshot of buy_price
ask_q  output  8  snapshot of sell_price
snap_valid  output  1  high once the first snapshot has been taken
cash  output  16  current cash
position  output  8  units held
trade_ok  output  1  one-cycle pulse when a trade commits
trade_rej  output  1  one-cycle pulse when a press is rejected
busy  output  1  high in CHECK and HOLDOFF

Behaviour:
Reset (reset low, asynchronous)
- bid_q=0, ask_q=0, snap_valid=0, cash=INIT_CASH, position=0.
- trade_ok=0, trade_rej=0, busy=0, tick counter=0, FSM=IDLE.
- Key synchronizers reset to 1 (released).
- Reset asserted mid-operation aborts any CHECK/HOLDOFF with no partial update.

Tick
- Counter runs 0..TICK_DIV-1 and wraps.
- At count==TICK_DIV-1: bid_q<=buy_price, ask_q<=sell_price, snap_valid<=1.

Keys
- Each key passes through a 2-flop synchronizer followed by one edge register.
- press = previous synced value 1 and current synced value 0.
- A press is visible 3 clk edges after the raw falling edge.
- Presses are acted on only in IDLE; presses in CHECK or HOLDOFF are dropped (not queued).

FSM
- IDLE: on any press, latch the request type (BUY, SELL or BOTH) and go to CHECK.
- CHECK (1 cycle): evaluate the request against bid_q/ask_q as they stand in this cycle. A snapshot update in the same edge does not affect the decision. Result is registered, then go to HOLDOFF.
  - BUY accepted iff snap_valid and cash >= ask_q and position < MAX_POS. Then cash <= cash - ask_q and position <= position + 1.
  - SELL accepted iff snap_valid and position > 0. Then cash <= min(cash + bid_q, 16'hFFFF) (saturating) and position <= position - 1.
  - BOTH (both presses in the same cycle): always rejected.
  - Accepted: trade_ok=1 for exactly the cycle after CHECK, coincident with the new cash/position becoming visible.
  - Rejected: trade_rej=1 for that cycle, with no register change.
- HOLDOFF: count HOLDOFF_CYC cycles, then go to IDLE. A press that becomes visible on the first IDLE cycle is accepted.
- busy = (state != IDLE).

Arithmetic
- Prices are unsigned 8-bit, zero-extended to 16 bits.
- A buy can never underflow cash, because it is guarded by the compare.

Decomposition:
Shared package trade_pkg:
- FSM state enum {IDLE, CHECK, HOLDOFF}.
- Request enum {REQ_NONE, REQ_BUY, REQ_SELL, REQ_BOTH}.
- Widths: PRICE_W=8, CASH_W=16, POS_W=8.

Sub-module key_edge_sync, instanced twice: 2-flop synchronizer plus falling-edge detect, reset value 1.
Tick counter, FSM and accounting stay in trade_controller.

Test Plan:
All scenarios use TICK_DIV=8, HOLDOFF_CYC=4, INIT_CASH=1000, MAX_POS=15.
1. Reset release, buy_price=60, sell_price=65 held -> snap_valid rises 8 cycles after reset release; bid_q=60, ask_q=65; cash=1000, position=0.
2. key_buy pulse before the first snapshot -> trade_rej pulse, cash stays 1000, busy high for 5 cycles.
3. After snapshot (ask=65), key_buy -> trade_ok, cash=935, position=1; second press during HOLDOFF -> ignored, no pulse.
4. position=1, bid=60, key_sell -> trade_ok, cash=995, position=0; further key_sell -> trade_rej, values unchanged.
5. key_buy and key_sell fall in the same cycle -> single trade_rej pulse, no change. Separately, cash=40 with ask=65 and key_buy -> trade_rej. Separately, 15 successful buys followed by a 16th buy -> trade_rej.
6. Saturation and reset: cash=65500, position=1, bid=62, key_sell -> cash=65535. Then assert reset during HOLDOFF -> all outputs return to reset values immediately.
